// File: rtl/cam_config_ctrl.sv
// Camera register-configuration sequencer: walks a {reg_addr, reg_data} ROM and
// issues one SCCB write per entry, honouring delay/end markers and NACK retries.
module cam_config_ctrl #(
    parameter int         CLK_FREQ_HZ = 25000000,
    parameter int         ROM_AW      = 7,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] DELAY_TAG   = 8'hF0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_config_start,
    output logic              o_config_done,
    output logic              o_config_error,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_start,
    output logic [7:0]        o_sccb_reg_addr,
    output logic [7:0]        o_sccb_reg_data,
    input  logic              i_sccb_busy,
    input  logic              i_sccb_done,
    input  logic              i_sccb_nack
);

    localparam int TICKS   = (CLK_FREQ_HZ / 1000 > 0) ? (CLK_FREQ_HZ / 1000) : 1;
    localparam int TICK_W  = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICKS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [ROM_AW-1:0]  LAST_INDEX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT_SCCB,
        S_DELAY,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [TICK_W-1:0]  r_tickCount;
    logic [7:0]         r_msCount;
    logic [RETRY_W-1:0] r_retryCount;

    logic [7:0] w_romRegAddr;
    logic [7:0] w_romRegData;
    logic       w_isEnd;
    logic       w_isDelay;
    logic       w_tickWrap;

    assign w_romRegAddr = i_rom_data[15:8];
    assign w_romRegData = i_rom_data[7:0];
    assign w_isEnd      = (i_rom_data == 16'hFFFF);
    assign w_isDelay    = (w_romRegAddr == DELAY_TAG);
    assign w_tickWrap   = (r_tickCount == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_config_start) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH: begin
                w_nextState = S_DECODE;
            end
            S_DECODE: begin
                if (w_isEnd) begin
                    w_nextState = S_DONE;
                end else if (w_isDelay) begin
                    w_nextState = (w_romRegData == 8'h00) ? S_NEXT : S_DELAY;
                end else begin
                    w_nextState = S_SEND;
                end
            end
            S_SEND: begin
                if (!i_sccb_busy) begin
                    w_nextState = S_WAIT_SCCB;
                end
            end
            S_WAIT_SCCB: begin
                if (i_sccb_done) begin
                    if (i_sccb_nack && (r_retryCount < RETRY_LIMIT)) begin
                        w_nextState = S_SEND;
                    end else begin
                        w_nextState = S_NEXT;
                    end
                end
            end
            S_DELAY: begin
                if (w_tickWrap && (r_msCount <= 8'd1)) begin
                    w_nextState = S_NEXT;
                end
            end
            S_NEXT: begin
                w_nextState = (o_rom_addr == LAST_INDEX) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_nextState = S_DONE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; o_sccb_start defaults low so it is a single-cycle pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_config_done   <= 1'b0;
            o_config_error  <= 1'b0;
            o_rom_addr      <= '0;
            o_sccb_start    <= 1'b0;
            o_sccb_reg_addr <= 8'h00;
            o_sccb_reg_data <= 8'h00;
            r_tickCount     <= '0;
            r_msCount       <= 8'h00;
            r_retryCount    <= '0;
        end else begin
            o_sccb_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_config_start) begin
                        o_rom_addr <= '0;
                    end
                end
                S_DECODE: begin
                    if (!w_isEnd) begin
                        if (w_isDelay) begin
                            r_msCount   <= w_romRegData;
                            r_tickCount <= '0;
                        end else begin
                            o_sccb_reg_addr <= w_romRegAddr;
                            o_sccb_reg_data <= w_romRegData;
                        end
                    end
                end
                S_SEND: begin
                    if (!i_sccb_busy) begin
                        o_sccb_start <= 1'b1;
                    end
                end
                S_WAIT_SCCB: begin
                    if (i_sccb_done) begin
                        if (!i_sccb_nack) begin
                            r_retryCount <= '0;
                        end else if (r_retryCount < RETRY_LIMIT) begin
                            r_retryCount <= r_retryCount + 1'b1;
                        end else begin
                            o_config_error <= 1'b1;
                            r_retryCount   <= '0;
                        end
                    end
                end
                S_DELAY: begin
                    if (w_tickWrap) begin
                        r_tickCount <= '0;
                        r_msCount   <= r_msCount - 8'd1;
                    end else begin
                        r_tickCount <= r_tickCount + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (o_rom_addr != LAST_INDEX) begin
                        o_rom_addr <= o_rom_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            if (w_nextState == S_DONE) begin
                o_config_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cam_config_ctrl.md
Name: cam_config_ctrl

Overview:
Camera register-configuration sequencer sitting between the top-level control FSM and the SCCB (I2C-like) master. When the control FSM raises o_config_start into this block's i_config_start, the block walks an external register ROM of {reg_addr, reg_data} pairs. It issues one SCCB write per entry, honours delay and end markers, retries NACKed writes, and then raises o_config_done back to the control FSM.

Parameters:
CLK_FREQ_HZ, 25000000, i_clk frequency; sets the 1 ms tick period (CLK_FREQ_HZ/1000 cycles).
ROM_AW, 7, ROM address width; the ROM holds 2^ROM_AW entries.
MAX_RETRY, 3, number of resends of a NACKed entry before it is skipped.
DELAY_TAG, 8'hF0, reg_addr value that marks a delay entry; reg_data gives the delay in ms.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  reset
i_config_start  in  1  level request from the control FSM; sampled only in IDLE
o_config_done  out  1  sticky high once the sequence completes
o_config_error  out  1  sticky high if any entry exhausted its retries
o_rom_addr  out  ROM_AW  registered ROM index
i_rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}; valid 1 cycle after o_rom_addr changes
o_sccb_start  out  1  1-cycle write-request pulse
o_sccb_reg_addr  out  8  register address; held stable from the start pulse until done
o_sccb_reg_data  out  8  register data; held stable from the start pulse until done
i_sccb_busy  in  1  SCCB master busy; no start pulse may be issued while it is high
i_sccb_done  in  1  1-cycle pulse at the end of a write
i_sccb_nack  in  1  NACK status; qualified by i_sccb_done in the same cycle

Behaviour:
- Reset is asynchronous, active-low, on i_reset_n; the clock is i_clk. All outputs are registered.
- Reset values: all outputs 0, index 0, retry count 0, delay counters 0, state IDLE.
- States:
  - IDLE: on i_config_start=1, set o_rom_addr=0 and go to FETCH.
  - FETCH: 1 wait cycle for the ROM, then go to DECODE.
  - DECODE: sample i_rom_data.
    - 16'hFFFF: go to DONE.
    - addr==DELAY_TAG: load the ms counter with data and go to DELAY. If data==0, go directly to NEXT.
    - Otherwise: latch addr/data onto o_sccb_reg_* and go to SEND.
  - SEND: when i_sccb_busy=0, pulse o_sccb_start for exactly 1 cycle and go to WAIT_SCCB. While busy=1, hold with no pulse.
  - WAIT_SCCB: act on i_sccb_done=1.
    - nack=0: clear the retry count and go to NEXT.
    - nack=1 and retry<MAX_RETRY: increment retry and go back to SEND (same entry, same data).
    - nack=1 and retry==MAX_RETRY: set o_config_error, clear retry, go to NEXT.
  - DELAY: a tick counter runs from 0 to CLK_FREQ_HZ/1000-1. At wrap it decrements the ms counter. When the ms counter reaches 0, go to NEXT. Total stall is data*CLK_FREQ_HZ/1000 cycles (±1).
  - NEXT: if index==2^ROM_AW-1, go to DONE (no wrap-around). Otherwise increment o_rom_addr and go to FETCH.
  - DONE: o_config_done=1 and stays high until reset. i_config_start is ignored from here.
- i_config_start falling mid-sequence is ignored; once started, the sequence runs to completion.
- An i_sccb_done pulse outside WAIT_SCCB is ignored.
- Reset asserted in any state aborts the sequence immediately: outputs return to reset values and the next start re-runs from index 0.
- Counter widths:
  - tick counter: $clog2(CLK_FREQ_HZ/1000).
  - ms counter: 8 bits.
  - retry counter: $clog2(MAX_RETRY+1).
- Per-entry latency from entering FETCH to the o_sccb_start pulse with busy=0: 3 cycles (FETCH, DECODE, SEND).

Test Plan:
1. Reset values: hold i_reset_n=0 and drive random inputs -> all outputs 0; release reset with start=0 -> block stays in IDLE with o_rom_addr=0.
2. Basic sequence: CLK_FREQ_HZ=4000; ROM = {12,80}, {F0,02}, {11,01}, FFFF; start=1; SCCB acks after 5 cycles -> exactly two writes, (0x12,0x80) then (0x11,0x01). Gap from the first done to the second start is 8 ticks ±1 plus fetch latency. done=1, error=0.
3. NACK retry: MAX_RETRY=2.
   - First write NACKed once -> (0x12,0x80) is resent, error stays 0.
   - First write NACKed 3 times -> 3 attempts in total, error=1, the next entry is still written, done=1.
4. Busy gating: hold i_sccb_busy=1 for 20 cycles while in SEND -> no o_sccb_start pulse. After busy falls, exactly one pulse appears the following cycle, and addr/data stay stable until done.
5. Reset mid-operation: assert reset during DELAY with the ms counter at 1 -> all outputs drop to 0 immediately. After release and start=1, the first write is again entry 0.
6. Boundaries:
   - Delay entry {F0,00} -> no stall; the next fetch happens on the following cycle.
   - ROM_AW=2 with no FFFF marker -> 4 writes, then done=1, and o_rom_addr never wraps to 0.
